// File: rtl/apb_master_module.sv
// apb_master_module
//
// Single-transfer APB master. A host command (cmd_*) is turned into one APB
// SETUP/ACCESS transfer, and the result is returned on a response channel
// (rsp_*) that is held until the host takes it. Only one transfer is ever in
// flight. Every output comes straight from a flop.
//
// Optional feature: define APB_MASTER_TIMEOUT_EN to enable the ACCESS
// wait-state timeout. TIMEOUT_CYCLES sets the limit. Without the macro, ACCESS
// waits forever for pready and rsp_timeout is tied low.
//
// Ports
//   pclk, preset_n          clock, synchronous active-low reset
//   cmd_valid/cmd_ready     host command handshake
//   cmd_write/addr/wdata    command payload
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata/err/timeout   response payload
//   psel_x, penable, pwrite, paddr, pwdata   APB request
//   pready, prdata, pslverr                  APB completion
//
// state  | meaning
// IDLE   | cmd_ready high; waiting for a host command
// SETUP  | APB setup phase (psel_x=1, penable=0), one cycle
// ACCESS | APB access phase; waiting for pready (or the timeout)
// RESP   | response presented; waiting for rsp_ready

module apb_master_module #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       rsp_timeout,
  output logic       psel_x,
  output logic       penable,
  output logic       pwrite,
  output logic [2:0] paddr,
  output logic [7:0] pwdata,
  input  logic       pready,
  input  logic [7:0] prdata,
  input  logic       pslverr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_module: TIMEOUT_CYCLES must be at least 1");
  end

  state_t     state_q, state_d;
  logic       cmd_ready_d;
  logic       psel_d, penable_d, pwrite_d;
  logic [2:0] paddr_d;
  logic [7:0] pwdata_d;
  logic       rsp_valid_d;
  logic [7:0] rsp_rdata_d;
  logic       rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready;
    psel_d      = psel_x;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        // cmd_ready is registered, so the cycle right after reset release
        // (cmd_ready still 0) cannot accept a command.
        if (cmd_valid && cmd_ready) begin
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          pwrite_d    = cmd_write;
          paddr_d     = cmd_addr;
          pwdata_d    = cmd_wdata;
          state_d     = SETUP;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt_d  = '0;
`endif
        end
      end

      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end

      ACCESS: begin
        // pready is checked first so a completion on the limit cycle wins.
        if (pready) begin
          rsp_rdata_d = pwrite ? 8'h00 : prdata;
          rsp_err_d   = pslverr;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
`ifdef APB_MASTER_TIMEOUT_EN
          timeout_d   = 1'b0;
        end else if (wait_cnt_q == CNT_LAST) begin
          // This stall cycle brings the count to TIMEOUT_CYCLES.
          rsp_rdata_d = 8'h00;
          rsp_err_d   = 1'b1;
          timeout_d   = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = RESP;
        end else begin
          wait_cnt_d  = wait_cnt_q + CNT_W'(1);
`endif
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q   <= IDLE;
      cmd_ready <= 1'b0;
      psel_x    <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 3'd0;
      pwdata    <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_ready <= cmd_ready_d;
      psel_x    <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign rsp_timeout = timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_module.sv
module tb_apb_master_module;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err, rsp_timeout;
  logic       psel_x, penable, pwrite;
  logic [2:0] paddr;
  logic [7:0] pwdata;
  logic       pready;
  logic [7:0] prdata;
  logic       pslverr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];

  always #5 pclk = ~pclk;

  apb_master_module #(.TIMEOUT_CYCLES(4)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel_x(psel_x), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: pops an expectation on every completed response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      #1;
      if (preset_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual=rdata %0h err %0b expected=no response @%0t",
                   rsp_rdata, rsp_err, $time);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_timeout", rsp_timeout, e.tmo);
        end
      end
    end
  end

  task automatic wait_cmd_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge pclk);
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
  endtask

  // One full transfer: waits = pready-low ACCESS cycles, hold = rsp_ready-low RESP cycles.
  task automatic run_txn(input logic w, input logic [2:0] a, input logic [7:0] wd,
                         input int waits, input logic [7:0] rd, input logic err,
                         input int hold);
    exp_t e;
    int   psel_cnt = 0;
    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
    pready = 1'b1; pslverr = 1'b1; prdata = 8'hFF;   // must be ignored outside ACCESS
    rsp_ready = (hold == 0);
    e.rdata = w ? 8'h00 : rd; e.err = err; e.tmo = 1'b0;
    exp_q.push_back(e);
    @(negedge pclk);                                  // SETUP
    chk("setup_psel", psel_x, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, a);
    chk("setup_pwrite", pwrite, w);
    chk("setup_pwdata", pwdata, wd);
    chk("setup_cmd_ready", cmd_ready, 0);
    if (psel_x === 1'b1) psel_cnt++;
    cmd_addr = a ^ 3'b111;                            // cmd_valid still high: must be ignored
    for (int i = 0; i <= waits; i++) begin
      @(negedge pclk);                                // ACCESS
      cmd_valid = 1'b0;
      chk("access_penable", penable, 1);
      chk("access_paddr", paddr, a);
      chk("access_pwdata", pwdata, wd);
      if (psel_x === 1'b1) psel_cnt++;
      pready  = (i == waits);
      prdata  = (i == waits) ? rd : 8'hEE;
      pslverr = (i == waits) ? err : 1'b0;
    end
    @(negedge pclk);                                  // RESP
    chk("psel_cycles", psel_cnt, waits + 2);
    chk("resp_psel", psel_x, 0);
    chk("resp_penable", penable, 0);
    chk("resp_valid", rsp_valid, 1);
    chk("resp_paddr_kept", paddr, a);
    pready = 1'b1; pslverr = 1'b1; prdata = 8'h99;
    for (int k = 0; k < hold; k++) begin
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_err", rsp_err, err);
      chk("hold_cmd_ready", cmd_ready, 0);
      @(negedge pclk);
    end
    rsp_ready = 1'b1;
    @(negedge pclk);                                  // back in IDLE
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_cmd_ready", cmd_ready, 1);
  endtask

  task automatic do_reset(input int cycles);
    preset_n = 1'b0;
    repeat (cycles) @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
  endtask

  initial begin
    exp_t e;
    preset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 3'd0;
    cmd_wdata = 8'h00; rsp_ready = 1'b0; pready = 1'b0; prdata = 8'h00; pslverr = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_psel", psel_x, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    preset_n = 1'b1;
    @(negedge pclk);
    chk("release_cmd_ready", cmd_ready, 1);

    run_txn(1'b1, 3'd2, 8'hA5, 0, 8'h00, 1'b0, 0);   // zero-wait write
    run_txn(1'b0, 3'd5, 8'h00, 3, 8'h3C, 1'b0, 0);   // read, 3 wait states
    run_txn(1'b0, 3'd7, 8'h11, 0, 8'h81, 1'b1, 4);   // slave error + backpressure
    run_txn(1'b1, 3'd0, 8'h5A, 1, 8'h77, 1'b0, 0);   // write with a wait state
    run_txn(1'b0, 3'd1, 8'h00, 0, 8'hC3, 1'b0, 0);   // back-to-back read

    // Reset in the middle of ACCESS: transfer aborted, no response.
    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd3; pready = 1'b0; rsp_ready = 1'b1;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk("pre_rst_penable", penable, 1);
    preset_n = 1'b0;
    @(negedge pclk);
    chk("abort_psel", psel_x, 0);
    chk("abort_penable", penable, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_paddr", paddr, 0);
    pready = 1'b1;
    @(negedge pclk);
    preset_n = 1'b1;
    @(negedge pclk);
    chk("abort_release_cmd_ready", cmd_ready, 1);
    repeat (5) @(negedge pclk);
    chk("abort_no_rsp", rsp_valid, 0);

    // Slave that never answers.
    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd6; pready = 1'b0; rsp_ready = 1'b1;
    @(negedge pclk);
    cmd_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    e.rdata = 8'h00; e.err = 1'b1; e.tmo = 1'b1;
    exp_q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      chk("tmo_access_penable", penable, 1);
    end
    @(negedge pclk);
    chk("tmo_psel", psel_x, 0);
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_err", rsp_err, 1);
    chk("tmo_rsp_timeout", rsp_timeout, 1);
    @(negedge pclk);
    chk("tmo_done_cmd_ready", cmd_ready, 1);
`else
    repeat (100) @(negedge pclk);
    chk("hang_psel", psel_x, 1);
    chk("hang_penable", penable, 1);
    chk("hang_paddr", paddr, 6);
    chk("hang_rsp_valid", rsp_valid, 0);
    do_reset(2);
    chk("hang_release_cmd_ready", cmd_ready, 1);
`endif

    repeat (3) @(negedge pclk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_module.md
APB_MASTER_MODULE -- requirements
Module: apb_master_module

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the wait-state limit in ACCESS (used only with APB_MASTER_TIMEOUT_EN).
REQ-002 SHALL have ports as follows:
- pclk  in  1  sole clock; all state changes on the rising edge.
- preset_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request from the host.
- cmd_ready  out  1  master can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  3  target register address.
- cmd_wdata  in  8  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  host consumes the response.
- rsp_rdata  out  8  read data (0 for writes).
- rsp_err  out  1  slave error or timeout.
- rsp_timeout  out  1  response caused by timeout.
- psel_x  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  3  APB address.
- pwdata  out  8  APB write data.
- pready  in  1  slave ready.
- prdata  in  8  slave read data.
- pslverr  in  1  slave error.

Function
REQ-003 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP, with all outputs registered.
REQ-004 IDLE behaviour:
- cmd_ready=1; psel_x=0; penable=0.
- If cmd_valid=1: latch cmd_write, cmd_addr and cmd_wdata into pwrite, paddr and pwdata, then go to SETUP.
REQ-005 SETUP behaviour: cmd_ready=0, psel_x=1, penable=0 for exactly one cycle, then go to ACCESS unconditionally.
REQ-006 ACCESS behaviour: psel_x=1, penable=1; hold while pready=0.
REQ-007 On pready=1 in ACCESS:
- Capture rsp_rdata = prdata for reads or 0x00 for writes.
- Capture rsp_err = pslverr.
- Go to RESP; psel_x and penable drop on the same edge.
REQ-008 paddr, pwrite and pwdata SHALL stay constant from SETUP through the end of ACCESS, and SHALL keep their last values in IDLE and RESP.
REQ-009 RESP behaviour:
- rsp_valid=1; rsp_rdata, rsp_err and rsp_timeout held stable.
- If rsp_ready=1: go to IDLE and clear rsp_valid on that edge.
- If rsp_ready=0: stay in RESP indefinitely.
REQ-010 Latency with zero wait states and rsp_ready tied high:
- Command accepted at edge N.
- SETUP during cycle N+1; ACCESS during N+2.
- rsp_valid high during N+3; cmd_ready high again at N+4.
REQ-011 Throughput: at most one outstanding transfer; cmd_valid is ignored outside IDLE.
REQ-012 pready and pslverr SHALL be ignored outside ACCESS.
REQ-013 pslverr=1 with pready=1 SHALL be a completed transfer with rsp_err=1; no retry is performed.

Reset
REQ-014 With preset_n=0 at a rising edge, the FSM SHALL go to IDLE and the outputs SHALL take these values:
- psel_x=0, penable=0, pwrite=0.
- paddr=0, pwdata=0.
- rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
- cmd_ready=0 during reset, 1 on the first cycle after release.
- Wait counter cleared.
REQ-015 Reset during SETUP, ACCESS or RESP SHALL abort the transfer with no response; psel_x and penable go low on the reset edge.

Configuration
REQ-016 Macro APB_MASTER_TIMEOUT_EN SHALL select the timeout feature.
REQ-017 With APB_MASTER_TIMEOUT_EN defined:
- A wait counter increments each ACCESS cycle with pready=0.
- When the counter reaches TIMEOUT_CYCLES, the master drops psel_x and penable, sets rsp_err=1, rsp_timeout=1 and rsp_rdata=0, then goes to RESP.
- The counter clears on entry to SETUP.
- pready=1 on the same cycle the limit is reached SHALL win: normal completion.
REQ-018 Without APB_MASTER_TIMEOUT_EN:
- No counter logic is present.
- ACCESS waits indefinitely for pready.
- rsp_timeout is tied to 0.

Verification
REQ-019 Zero-wait write: cmd_write=1, addr=3'd2, wdata=8'hA5, pready=1, rsp_ready=1.
- APB: SETUP then ACCESS with paddr=2, pwdata=A5, pwrite=1.
- Response: rsp_valid one cycle at N+3, rsp_rdata=00, rsp_err=0.
REQ-020 Read with 3 wait states: addr=3'd5; pready=0 for 3 ACCESS cycles, then 1 with prdata=8'h3C.
- Response: rsp_rdata=3C, rsp_err=0.
- psel_x high 5 cycles; paddr stable throughout.
REQ-021 Slave error with backpressure: pslverr=1 with pready=1; rsp_ready held 0 for 4 cycles.
- rsp_valid and rsp_err=1 held 4+ cycles; cmd_ready=0 until the handshake completes.
REQ-022 Reset mid-ACCESS: preset_n=0 while penable=1.
- Next cycle psel_x=0, penable=0, rsp_valid=0; no response is ever issued.
REQ-023 Timeout, TIMEOUT_CYCLES=4, macro defined: pready held 0.
- After 4 ACCESS cycles: rsp_err=1, rsp_timeout=1, psel_x=0.
- Same stimulus without the macro: still in ACCESS after 100 cycles.
